// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock through a ripple chain of
// full-adder cells, with a start/busy/done handshake and registered sum, cout and ovf.
module serial_adder_sub #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder_sub: WIDTH must be at least 2");
  end
  if ((BITS_PER_CYCLE == 0) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_bpc
    $error("serial_adder_sub: BITS_PER_CYCLE must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic                 carry_q, carry_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic [BITS_PER_CYCLE-1:0] chunk_sum;
  logic                      chunk_cout;
  logic                      msb_cin;
  logic                      rip_c;

  // Ripple chain over the low chunk; msb_cin keeps the carry into the chunk's top cell,
  // which on the final chunk is the carry into the result MSB.
  always_comb begin
    rip_c     = carry_q;
    msb_cin   = carry_q;
    chunk_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      msb_cin      = rip_c;
      chunk_sum[i] = op_a_q[i] ^ op_b_q[i] ^ rip_c;
      rip_c        = (op_a_q[i] & op_b_q[i]) | (rip_c & (op_a_q[i] ^ op_b_q[i]));
    end
    chunk_cout = rip_c;
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        op_a_d  = op_a_q >> BITS_PER_CYCLE;
        op_b_d  = op_b_q >> BITS_PER_CYCLE;
        // New chunk enters at the MSB end so the first chunk ends up in the LSBs.
        res_d   = WIDTH'({chunk_sum, res_q} >> BITS_PER_CYCLE);
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = res_d;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cout ^ msb_cin;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: five parameterisations checked every cycle against an
// arithmetic model of the handshake and result, plus literal and exhaustive cases.
module tb_serial_adder_sub;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0]      start_v, sub_v;
  logic [NI-1:0][7:0] a_v, b_v;
  wire  [NI-1:0]      busy_v, done_v, cout_v, ovf_v;
  wire  [NI-1:0][7:0] sum_v;

  function automatic int w_of(input int g);
    return (g < 2) ? 8 : 4;
  endfunction

  function automatic int bpc_of(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 1;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int n_of(input int g);
    return w_of(g) / bpc_of(g);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = (g < 2) ? 8 : 4;
    localparam int unsigned B = (g == 1 || g == 4) ? 4 : ((g == 3) ? 2 : 1);
    wire [W-1:0] s;
    serial_adder_sub #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_v[g]),
      .sub  (sub_v[g]),
      .a    (a_v[g][W-1:0]),
      .b    (b_v[g][W-1:0]),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .sum  (s),
      .cout (cout_v[g]),
      .ovf  (ovf_v[g])
    );
    assign sum_v[g] = 8'(s);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Model: edges left in the current operation, plus pending and visible results.
  int m_left[NI];
  bit m_done[NI];
  int m_sum[NI], p_sum[NI];
  bit m_cout[NI], p_cout[NI], m_ovf[NI], p_ovf[NI];

  task automatic model_op(input int g, input logic [7:0] a, input logic [7:0] b,
                          input logic s);
    int w, mask, ua, ub, sa, sb, r, sr;
    w    = w_of(g);
    mask = (1 << w) - 1;
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    r    = s ? ua - ub : ua + ub;
    sr   = s ? sa - sb : sa + sb;
    p_sum[g]  = r & mask;
    p_cout[g] = s ? (ua >= ub) : (r > mask);
    p_ovf[g]  = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
  endtask

  // Inputs only change 1 time unit after a falling edge, so at the falling edge they
  // still hold the values the preceding rising edge sampled.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_left[g] = 0;
        m_done[g] = 1'b0;
        m_sum[g]  = 0;
        m_cout[g] = 1'b0;
        m_ovf[g]  = 1'b0;
      end else begin
        m_done[g] = 1'b0;
        if (m_left[g] > 0) begin
          m_left[g]--;
          if (m_left[g] == 0) begin
            m_done[g] = 1'b1;
            m_sum[g]  = p_sum[g];
            m_cout[g] = p_cout[g];
            m_ovf[g]  = p_ovf[g];
          end
        end else if (start_v[g]) begin
          model_op(g, a_v[g], b_v[g], sub_v[g]);
          m_left[g] = n_of(g);
        end
      end
      chk("busy", g, 32'(busy_v[g]), 32'(m_left[g] > 0));
      chk("done", g, 32'(done_v[g]), 32'(m_done[g]));
      chk("sum",  g, 32'(sum_v[g]),  32'(m_sum[g]));
      chk("cout", g, 32'(cout_v[g]), 32'(m_cout[g]));
      chk("ovf",  g, 32'(ovf_v[g]),  32'(m_ovf[g]));
    end
  end

  task automatic do_op(input int g, input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output int bcnt);
    int n;
    n    = n_of(g);
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    #1;
    a_v[g]     = a;
    b_v[g]     = b;
    sub_v[g]   = s;
    start_v[g] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_v[g]) bcnt++;
      if (done_v[g]) begin
        lat = k;
        break;
      end
      #1;
      // Noise during RUN must be ignored; start drops before the DONE-cycle edge.
      start_v[g] = (k < n) ? 1'($urandom) : 1'b0;
      a_v[g]     = 8'($urandom);
      b_v[g]     = 8'($urandom);
      sub_v[g]   = 1'($urandom);
    end
  endtask

  task automatic expect_op(input string nm, input int g, input logic [7:0] a,
                           input logic [7:0] b, input logic s, input logic [7:0] es,
                           input logic ec, input logic eo);
    int lat, bcnt;
    do_op(g, a, b, s, lat, bcnt);
    chk({nm, "_sum"},  g, 32'(sum_v[g]), 32'(es));
    chk({nm, "_cout"}, g, 32'(cout_v[g]), 32'(ec));
    chk({nm, "_ovf"},  g, 32'(ovf_v[g]), 32'(eo));
    chk({nm, "_lat"},  g, 32'(lat), 32'(n_of(g) + 1));
    chk({nm, "_busy"}, g, 32'(bcnt), 32'(n_of(g)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, dcnt;
    logic [4:0] full;
    logic [3:0] bb, rs;
    rst     = 1'b1;
    start_v = '0;
    sub_v   = '0;
    a_v     = '0;
    b_v     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_sum", 0, 32'(sum_v[0]), 32'd0);
    #1 rst = 1'b0;

    expect_op("ff_p_01", 0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    expect_op("7f_p_01", 0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    expect_op("05_m_07", 0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    expect_op("80_m_01", 0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    expect_op("3c_p_4a", 1, 8'h3C, 8'h4A, 1'b0, 8'h86, 1'b0, 1'b1);

    // Start held high: one result every N+1 = 3 cycles.
    dcnt = 0;
    @(negedge clk);
    #1 start_v[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done_v[1]) dcnt++;
      #1;
      if (k == 12) start_v[1] = 1'b0;
      else begin
        a_v[1]   = 8'($urandom);
        b_v[1]   = 8'($urandom);
        sub_v[1] = 1'($urandom);
      end
    end
    chk("b2b_dones", 1, 32'(dcnt), 32'd4);

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    #1;
    a_v[0] = 8'h12; b_v[0] = 8'h34; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    #1 start_v[0] = 1'b0;
    @(negedge clk);
    chk("mid_busy", 0, 32'(busy_v[0]), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("arst_done", 0, 32'(done_v[0]), 32'd0);
    chk("arst_sum",  0, 32'(sum_v[0]),  32'd0);
    chk("arst_cout", 0, 32'(cout_v[0]), 32'd0);
    chk("arst_ovf",  0, 32'(ovf_v[0]),  32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dcnt++;
    end
    chk("arst_nodone", 0, 32'(dcnt), 32'd0);
    expect_op("12_p_34", 0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Random traffic on the 8-bit instances, checked by the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      do_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), lat, bcnt);
      chk("rnd_lat", i % 2, 32'(lat), 32'(n_of(i % 2) + 1));
    end

    // Exhaustive 4-bit sweep for every chunk size.
    for (int g = 2; g < NI; g++) begin
      for (int s = 0; s < 2; s++) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            do_op(g, 8'(a), 8'(b), 1'(s), lat, bcnt);
            bb   = (s == 1) ? ~4'(b) : 4'(b);
            full = 5'(a) + 5'(bb) + 5'(s);
            rs   = full[3:0];
            chk("ex_sum",  g, 32'(sum_v[g]),  32'(rs));
            chk("ex_cout", g, 32'(cout_v[g]), 32'(full[4]));
            chk("ex_ovf",  g, 32'(ovf_v[g]),
                32'((a[3] == bb[3]) && (rs[3] != a[3])));
            chk("ex_lat",  g, 32'(lat), 32'(n_of(g) + 1));
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised, multi-cycle successor to the team's combinational half adder.
- Adds or subtracts two WIDTH-bit operands, processing BITS_PER_CYCLE bits per clock through a ripple chain of full-adder cells.
- Produces sum, carry-out and signed overflow, with a start/busy/done handshake.
- Used where area matters more than latency; the datapath scales by parameter instead of by duplicating cells.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- BITS_PER_CYCLE, 1, bits processed per RUN cycle. Must divide WIDTH exactly; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled on rising edge.
- sub  input  1  0 = a+b, 1 = a-b; latched on accepted start.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse: result registers just updated.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  carry out of the MSB. For sub this means no-borrow (1 when a>=b unsigned).
- ovf  output  1  two's-complement overflow of the last result.

Behaviour:
- Only one clock and one reset exist. rst is asynchronous, active-high. While asserted:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0, ovf = 0
  - internal shift, count and carry registers = 0
- Reset asserted mid-RUN aborts the operation; no done is produced.
- N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 is accepted.
  - opA <= a; opB <= sub ? ~b : b; carry <= sub; cnt <= 0.
  - Next state RUN.
- RUN (busy=1):
  - Each edge adds the low BITS_PER_CYCLE bits of opA, opB and carry through a chain of full adders.
  - opA and opB shift right by BITS_PER_CYCLE.
  - The chunk sum enters the MSB end of the internal result shift register.
  - carry <= chunk carry-out; cnt <= cnt+1.
  - On the edge where cnt == N-1, the final chunk is processed and then:
    - sum <= the complete result.
    - cout <= final carry.
    - ovf <= carry into the MSB XOR carry out of the MSB, both taken from the final chunk.
    - State goes to DONE.
  - start is ignored during RUN, and a, b and sub are not sampled.
- DONE:
  - done=1, busy=0, for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation), giving next state RUN. Otherwise the next state is IDLE.
- Latency: start accepted at edge E gives done high in the cycle after edge E+N. Throughput is one result per N+1 cycles.
- sum, cout and ovf change only on the completion edge. They are stable throughout RUN of the following operation.
- Arithmetic is modulo 2^WIDTH. cout and ovf are both meaningful for add and for sub.
- Values of a, b and sub changing after acceptance have no effect.

Test Plan:
- WIDTH=8, BPC=1: add FF+01 -> sum=00, cout=1, ovf=0. busy high for 8 cycles; done pulses once, 9 cycles after the start edge.
- WIDTH=8, BPC=1: add 7F+01 -> sum=80, cout=0, ovf=1. Then sub 05-07 -> sum=FE, cout=0, ovf=0. Then sub 80-01 -> sum=7F, cout=1, ovf=1.
- WIDTH=8, BPC=4: add 3C+4A -> sum=86, cout=0, ovf=1, with done 3 cycles after start. Hold start high continuously -> back-to-back results every 3 cycles.
- Start pulses and operand changes during RUN -> ignored. Result equals the originally latched operation, and sum does not change until the completion edge.
- rst asserted asynchronously mid-RUN, between clock edges -> outputs go to 0 immediately with no done. After release, a new start completes correctly.
- WIDTH=4, BPC in {1,2,4}: exhaustive loop over all a, b and both sub values (512 cases). Compare sum, cout and ovf against a behavioural {cout,sum} = a ± b model with signed overflow.
